// File: rtl/twotoone_mux_nand_behav.sv
// twotoone_mux_nand_behav: 2:1 mux built purely from 2-input NANDs, with optional output register
module twotoone_mux_nand_behav #(
  parameter int WIDTH = 1,
  parameter bit REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z_comb,
  output logic [WIDTH-1:0] Z,
  output logic             valid
);
  logic             n_s;
  logic [WIDTH-1:0] n1, n2;
  assign n_s    = ~(S & S);
  assign n1     = ~(A & {WIDTH{n_s}});
  assign n2     = ~(B & {WIDTH{S}});
  assign Z_comb = ~(n1 & n2);
  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] z_d, z_q;
    logic             valid_d, valid_q;
    always_comb begin
      z_d     = Z_comb;
      valid_d = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        z_q     <= z_d;
        valid_q <= valid_d;
      end
    end
    assign Z     = z_q;
    assign valid = valid_q;
  end else begin : g_comb
    assign Z     = Z_comb;
    assign valid = rst_n;
  end
endmodule

// File: tb/tb_twotoone_mux_nand_behav.sv
// tb_twotoone_mux_nand_behav: randomized self-checking bench against a behavioural mux model
module tb_twotoone_mux_nand_behav;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic z1c, z1, v1;
  logic s8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, z8c, z8;
  logic v8;
  logic s0 = 1'b0, a0 = 1'b0, b0 = 1'b0;
  logic z0c, z0, v0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  twotoone_mux_nand_behav #(.WIDTH(1), .REGISTERED(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .S(s1), .A(a1), .B(b1), .Z_comb(z1c), .Z(z1), .valid(v1));
  twotoone_mux_nand_behav #(.WIDTH(8), .REGISTERED(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .S(s8), .A(a8), .B(b8), .Z_comb(z8c), .Z(z8), .valid(v8));
  twotoone_mux_nand_behav #(.WIDTH(1), .REGISTERED(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .S(s0), .A(a0), .B(b0), .Z_comb(z0c), .Z(z0), .valid(v0));

  function automatic logic [7:0] mux_ref(input logic sel, input logic [7:0] x, input logic [7:0] y);
    return sel ? y : x;
  endfunction

  task automatic test_reset();
    s1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    s8 = 1'b0; a8 = 8'h5A; b8 = 8'hFF;
    #3;
    checks++; if (z1 !== 1'b0) begin errors++; $display("FAIL reset_z1 got=%b exp=0", z1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_v1 got=%b exp=0", v1); end
    checks++; if (z8 !== 8'h00) begin errors++; $display("FAIL reset_z8 got=%h exp=00", z8); end
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_v8 got=%b exp=0", v8); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_v0 got=%b exp=0", v0); end
    checks++; if (z1c !== 1'b1) begin errors++; $display("FAIL reset_zcomb1 got=%b exp=1", z1c); end
    @(posedge clk); #1;
    checks++; if (z1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL reset_hold z1=%b v1=%b exp=0/0", z1, v1); end
    rst_n = 1'b1;
    #1;
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL release_v0 got=%b exp=1", v0); end
    @(posedge clk); #1;
    checks++; if (z1 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL first_edge z1=%b v1=%b exp=1/1", z1, v1); end
    checks++; if (z8 !== 8'h5A || v8 !== 1'b1) begin errors++; $display("FAIL first_edge8 z8=%h v8=%b exp=5a/1", z8, v8); end
  endtask

  task automatic test_truth_table();
    logic [2:0] tbl [4] = '{3'b000, 3'b101, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      logic exp;
      {s1, a1, b1} = tbl[i];
      {s0, a0, b0} = tbl[i];
      exp = tbl[i][2] ? tbl[i][0] : tbl[i][1];
      #1;
      checks++; if (z1c !== exp) begin errors++; $display("FAIL tt_zcomb[%0d] got=%b exp=%b", i, z1c, exp); end
      checks++; if (z0 !== exp || z0c !== exp) begin errors++; $display("FAIL tt_comb_z[%0d] got=%b/%b exp=%b", i, z0, z0c, exp); end
      checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL tt_comb_valid[%0d] got=%b exp=1", i, v0); end
      @(posedge clk); #1;
      checks++; if (z1 !== exp) begin errors++; $display("FAIL tt_z[%0d] got=%b exp=%b", i, z1, exp); end
    end
  endtask

  task automatic test_isolation();
    logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      s1 = 1'b0; a1 = 1'b1; b1 = i[0];
      #1;
      checks++; if (z1c !== 1'b1) begin errors++; $display("FAIL iso_a_zcomb[%0d] got=%b exp=1", i, z1c); end
      @(posedge clk); #1;
      checks++; if (z1 !== 1'b1) begin errors++; $display("FAIL iso_a_z[%0d] got=%b exp=1", i, z1); end
    end
    for (int i = 0; i < 4; i++) begin
      s1 = 1'b1; b1 = 1'b0; a1 = seq[i][0];
      #1;
      checks++; if (z1c !== 1'b0) begin errors++; $display("FAIL iso_b_zcomb[%0d] got=%b exp=0", i, z1c); end
      @(posedge clk); #1;
      checks++; if (z1 !== 1'b0) begin errors++; $display("FAIL iso_b_z[%0d] got=%b exp=0", i, z1); end
    end
  endtask

  task automatic test_async_reset();
    s1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    s8 = 1'b1; b8 = 8'hC3;
    @(posedge clk); #1;
    checks++; if (z1 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL ar_pre z1=%b v1=%b exp=1/1", z1, v1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (z1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL ar_async z1=%b v1=%b exp=0/0", z1, v1); end
    checks++; if (z8 !== 8'h00 || v8 !== 1'b0) begin errors++; $display("FAIL ar_async8 z8=%h v8=%b exp=00/0", z8, v8); end
    checks++; if (z1c !== 1'b1 || z8c !== 8'hC3) begin errors++; $display("FAIL ar_zcomb z1c=%b z8c=%h exp=1/c3", z1c, z8c); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL ar_comb_valid got=%b exp=0", v0); end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (z1 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL ar_released_pre_edge z1=%b v1=%b exp=0/0", z1, v1); end
    @(posedge clk); #1;
    checks++; if (z1 !== 1'b1 || v1 !== 1'b1) begin errors++; $display("FAIL ar_post z1=%b v1=%b exp=1/1", z1, v1); end
    checks++; if (z8 !== 8'hC3 || v8 !== 1'b1) begin errors++; $display("FAIL ar_post8 z8=%h v8=%b exp=c3/1", z8, v8); end
  endtask

  task automatic test_width8();
    logic [7:0] prev;
    a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
    #1;
    checks++; if (z8c !== 8'hA5) begin errors++; $display("FAIL w8_sel_a got=%h exp=a5", z8c); end
    s8 = 1'b1;
    #1;
    checks++; if (z8c !== 8'h3C) begin errors++; $display("FAIL w8_sel_b got=%h exp=3c", z8c); end
    @(posedge clk); #1;
    prev = 8'h3C;
    for (int i = 0; i < 1000; i++) begin
      s8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      #1;
      if (z8c !== mux_ref(s8, a8, b8)) begin
        errors++; checks++; $display("FAIL w8_rand_zcomb[%0d] got=%h exp=%h", i, z8c, mux_ref(s8, a8, b8));
      end else checks++;
      checks++; if (z8 !== prev) begin errors++; $display("FAIL w8_rand_hold[%0d] got=%h exp=%h", i, z8, prev); end
      prev = mux_ref(s8, a8, b8);
      @(posedge clk); #1;
      checks++; if (z8 !== prev) begin errors++; $display("FAIL w8_rand_z[%0d] got=%h exp=%h", i, z8, prev); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    for (int i = 0; i < 50; i++) begin
      s1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      s0 = s1; a0 = a1; b0 = b1;
      exp = mux_ref(s1, {7'b0, a1}, {7'b0, b1}) != 8'h00;
      #1;
      checks++; if (z0 !== exp) begin errors++; $display("FAIL b2b_comb_z[%0d] got=%b exp=%b", i, z0, exp); end
      @(posedge clk); #1;
      checks++; if (z1 !== exp) begin errors++; $display("FAIL b2b_z[%0d] got=%b exp=%b", i, z1, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_isolation();
    test_async_reset();
    test_width8();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
